aug_pingpong_sched: RTL

// Sequences the resized-crop augmentation stage over two ping-pong BRAM banks. Incoming pixels are written into one bank

---
 rtl/aug_pkg.sv | 24 ++
 rtl/aug_bank_writer.sv | 46 ++++
 rtl/aug_pingpong_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/aug_pkg.sv
// Shared types and default geometry for the ping-pong augmentation scheduler.
package aug_pkg;

   localparam int unsigned IMG_PIXELS = 784;
   localparam int unsigned ADDR_W     = 11;
   localparam int unsigned PIX_W      = 8;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
   typedef enum logic [1:0] {IDLE, START, WAIT} drain_state_t;

   function automatic logic is_writable(input bank_state_t s);
      return (s == EMPTY) || (s == FILLING);
   endfunction

   // Number of banks holding a complete image (waiting or being cropped).
   function automatic logic [1:0] count_held(input bank_state_t s0, input bank_state_t s1);
      logic [1:0] n;
      n = 2'd0;
      if (s0 == FULL || s0 == DRAINING) n = n + 2'd1;
      if (s1 == FULL || s1 == DRAINING) n = n + 2'd1;
      return n;
   endfunction

endpackage

// File: rtl/aug_bank_writer.sv
// Fill side: accepts pixels into the current write bank and issues the registered BRAM write.
module aug_bank_writer #(
   parameter int unsigned IMG_PIXELS = aug_pkg::IMG_PIXELS,
   parameter int unsigned ADDR_W     = aug_pkg::ADDR_W,
   parameter int unsigned PIX_W      = aug_pkg::PIX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PIX_W-1:0]  s_pixel,
   input  logic              s_valid,
   input  logic [1:0]        bank_free,
   output logic              s_ready,
   output logic              wbank,
   output logic              hs_c,
   output logic              fill_done_c,
   output logic [1:0]        bank_we,
   output logic [ADDR_W-1:0] bank_waddr,
   output logic [PIX_W-1:0]  bank_wdata
);

   logic [ADDR_W-1:0] wcnt;

   assign s_ready     = bank_free[wbank];
   assign hs_c        = s_valid && s_ready;
   assign fill_done_c = hs_c && (wcnt == ADDR_W'(IMG_PIXELS - 1));

   // Write port is registered one cycle behind the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         wbank      <= 1'b0;
         wcnt       <= '0;
         bank_we    <= 2'b00;
         bank_waddr <= '0;
         bank_wdata <= '0;
      end else begin
         bank_we <= hs_c ? (wbank ? 2'b10 : 2'b01) : 2'b00;
         if (hs_c) begin
            bank_waddr <= wcnt;
            bank_wdata <= s_pixel;
            wcnt       <= fill_done_c ? '0 : wcnt + ADDR_W'(1);
         end
         if (fill_done_c) wbank <= ~wbank;
      end
   end

endmodule

// File: rtl/aug_pingpong_sched.sv
// Ping-pong bank scheduler: tracks bank ownership, sequences crop start/done, and muxes crop reads.
module aug_pingpong_sched #(
   parameter int unsigned IMG_PIXELS   = aug_pkg::IMG_PIXELS,
   parameter int unsigned ADDR_W       = aug_pkg::ADDR_W,
   parameter int unsigned PIX_W        = aug_pkg::PIX_W,
   parameter int unsigned START_LEN    = 2,
   parameter int unsigned DONE_TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PIX_W-1:0]  s_pixel,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [1:0]        bank_we,
   output logic [ADDR_W-1:0] bank_waddr,
   output logic [PIX_W-1:0]  bank_wdata,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] bank_raddr,
   input  logic [PIX_W-1:0]  bank_rdata0,
   input  logic [PIX_W-1:0]  bank_rdata1,
   output logic [PIX_W-1:0]  rd_data,
   output logic              crop_start,
   input  logic              crop_done,
   output logic [1:0]        banks_full,
   output logic              timeout_err
);
   import aug_pkg::*;

   localparam int unsigned SCNT_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;

   bank_state_t       bstate [2];
   bank_state_t       bs_nxt [2];
   drain_state_t      dstate, dnext;
   logic              wbank, rbank, rsel_d;
   logic              hs_c, fill_done_c;
   logic [SCNT_W-1:0] scnt;
   logic [15:0]       tcnt;
   logic              timeout_hit_c, start_go_c, release_c, forced_c, crop_start_nxt;

   aug_bank_writer #(
      .IMG_PIXELS (IMG_PIXELS),
      .ADDR_W     (ADDR_W),
      .PIX_W      (PIX_W)
   ) u_writer (
      .clk         (clk),
      .reset       (reset),
      .s_pixel     (s_pixel),
      .s_valid     (s_valid),
      .bank_free   ({is_writable(bstate[1]), is_writable(bstate[0])}),
      .s_ready     (s_ready),
      .wbank       (wbank),
      .hs_c        (hs_c),
      .fill_done_c (fill_done_c),
      .bank_we     (bank_we),
      .bank_waddr  (bank_waddr),
      .bank_wdata  (bank_wdata)
   );

   assign timeout_hit_c = (DONE_TIMEOUT != 0) && (tcnt == 16'(DONE_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) dstate <= IDLE;
      else       dstate <= dnext;
   end

   always_comb begin
      dnext = dstate;
      case (dstate)
         IDLE:    if (bstate[rbank] == FULL) dnext = START;
         START:   if (scnt == SCNT_W'(START_LEN - 1)) dnext = WAIT;
         WAIT:    if (crop_done || timeout_hit_c) dnext = IDLE;
         default: dnext = IDLE;
      endcase
   end

   always_comb begin
      start_go_c     = (dstate == IDLE) && (dnext == START);
      release_c      = (dstate == WAIT) && (dnext == IDLE);
      forced_c       = release_c && !crop_done;
      crop_start_nxt = (dnext == START);
   end

   // Fill and drain always target different banks, so both updates can land together.
   always_comb begin
      bs_nxt = bstate;
      if (hs_c)       bs_nxt[wbank] = fill_done_c ? FULL : FILLING;
      if (start_go_c) bs_nxt[rbank] = DRAINING;
      if (release_c)  bs_nxt[rbank] = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bstate[0]   <= EMPTY;
         bstate[1]   <= EMPTY;
         rbank       <= 1'b0;
         rsel_d      <= 1'b0;
         scnt        <= '0;
         tcnt        <= '0;
         crop_start  <= 1'b0;
         timeout_err <= 1'b0;
         banks_full  <= 2'd0;
      end else begin
         bstate      <= bs_nxt;
         rsel_d      <= rbank;
         scnt        <= (dstate == START) ? scnt + SCNT_W'(1) : '0;
         tcnt        <= (dstate != WAIT) ? 16'd0 : ((tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1);
         crop_start  <= crop_start_nxt;
         timeout_err <= timeout_err | forced_c;
         banks_full  <= count_held(bs_nxt[0], bs_nxt[1]);
         if (release_c) rbank <= ~rbank;
      end
   end

   assign bank_raddr = rd_addr;
   assign rd_data    = rsel_d ? bank_rdata1 : bank_rdata0;

endmodule
